// File: rtl/plane_result_packetizer.sv
// plane_result_packetizer
//
// Pairs each plane result with the matching accumulated sphere surface and emits a
// 4-word frame on a 32-bit valid/ready stream:
//   word 0  header   {SYNC_BYTE, seq, ovf_cnt, 6'b0, surf_missing, plane_missing}
//   word 1  plane result (0 if missing)
//   word 2  surface      (0 if missing)
//   word 3  checksum = word0 ^ word1 ^ word2, flagged with m_last
//
// A pending slot collects the next pair while a frame is being transmitted from the
// tx slot, so one complete pair can be queued behind an in-flight frame. If only one
// half of a pair shows up, a wait counter forces a partial frame after TIMEOUT_CYC
// cycles. A result that replaces a still-pending one is counted in ovf_cnt.
//
// Ports
//   clk         system clock
//   rst         asynchronous reset, active low
//   plane_en    1-cycle strobe qualifying plane_data
//   plane_data  plane result
//   surf_en     1-cycle strobe qualifying surf_data
//   surf_data   accumulated sphere surface
//   m_data      stream data (registered)
//   m_valid     stream valid (registered, never retracted before acceptance)
//   m_ready     stream ready from the consumer
//   m_last      marks the checksum word (registered)
//   busy        a frame is in flight
//   ovf_cnt     saturating count of overwritten pending results

module plane_result_packetizer #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        plane_en,
  input  logic [31:0] plane_data,
  input  logic        surf_en,
  input  logic [31:0] surf_data,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        busy,
  output logic [7:0]  ovf_cnt
);

  // TIMEOUT_CYC - 1 always fits in $clog2(TIMEOUT_CYC) bits for TIMEOUT_CYC >= 2.
  localparam int unsigned CntW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StPlane,
    StSurf,
    StCsum
  } state_e;

  state_e         state_q;

  // Pending slot
  logic [31:0]    plane_q;
  logic [31:0]    surf_q;
  logic           pv_q;
  logic           sv_q;
  logic [CntW-1:0] wait_q;
  logic [CntW-1:0] wait_d;
  logic [7:0]     ovf_q;
  logic [7:0]     ovf_d;

  // Tx slot
  logic [31:0]    tx_plane_q;
  logic [31:0]    tx_surf_q;
  logic [31:0]    tx_hdr_q;
  logic [7:0]     seq_q;

  logic           timeout;
  logic           promote;
  logic           plane_ovf;
  logic           surf_ovf;
  logic [8:0]     ovf_sum;
  logic [31:0]    hdr_word;
  logic           xfer;

  // Exactly one half present and it has waited long enough.
  assign timeout = (pv_q ^ sv_q) && (wait_q == CntMax);
  assign promote = (state_q == StIdle) && ((pv_q && sv_q) || timeout);

  // A strobe in the promotion cycle refills an emptied slot, so it is not an overwrite.
  assign plane_ovf = plane_en && pv_q && !promote;
  assign surf_ovf  = surf_en && sv_q && !promote;

  // ovf_q is stable in the promotion cycle (no overwrite can be counted then).
  assign hdr_word = {SYNC_BYTE, seq_q, ovf_q, 6'b0, ~sv_q, ~pv_q};

  assign xfer = m_valid && m_ready;

  always_comb begin
    ovf_sum = {1'b0, ovf_q} + {8'b0, plane_ovf} + {8'b0, surf_ovf};
    ovf_d   = ovf_sum[8] ? 8'hFF : ovf_sum[7:0];
  end

  always_comb begin
    wait_d = '0;
    if ((pv_q ^ sv_q) && !promote) begin
      // Hold at the terminal count until the FSM is free to promote.
      wait_d = (wait_q == CntMax) ? CntMax : wait_q + 1'b1;
    end
  end

  // Pending slot, wait counter and overflow counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      plane_q <= '0;
      surf_q  <= '0;
      pv_q    <= 1'b0;
      sv_q    <= 1'b0;
      wait_q  <= '0;
      ovf_q   <= '0;
    end else begin
      if (plane_en) begin
        plane_q <= plane_data;
      end
      if (surf_en) begin
        surf_q <= surf_data;
      end
      pv_q   <= plane_en | (pv_q & ~promote);
      sv_q   <= surf_en | (sv_q & ~promote);
      wait_q <= wait_d;
      ovf_q  <= ovf_d;
    end
  end

  // Frame FSM with registered stream outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      tx_plane_q <= '0;
      tx_surf_q  <= '0;
      tx_hdr_q   <= '0;
      seq_q      <= '0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (promote) begin
            tx_plane_q <= pv_q ? plane_q : 32'h0;
            tx_surf_q  <= sv_q ? surf_q : 32'h0;
            tx_hdr_q   <= hdr_word;
            m_data     <= hdr_word;
            m_valid    <= 1'b1;
            m_last     <= 1'b0;
            state_q    <= StHdr;
          end
        end
        StHdr: begin
          if (xfer) begin
            m_data  <= tx_plane_q;
            state_q <= StPlane;
          end
        end
        StPlane: begin
          if (xfer) begin
            m_data  <= tx_surf_q;
            state_q <= StSurf;
          end
        end
        StSurf: begin
          if (xfer) begin
            m_data  <= tx_hdr_q ^ tx_plane_q ^ tx_surf_q;
            m_last  <= 1'b1;
            state_q <= StCsum;
          end
        end
        StCsum: begin
          if (xfer) begin
            m_data  <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            seq_q   <= seq_q + 8'd1;
            state_q <= StIdle;
          end
        end
        default: begin
          m_valid <= 1'b0;
          m_last  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy    = (state_q != StIdle);
  assign ovf_cnt = ovf_q;

endmodule

// File: tb/tb_plane_result_packetizer.sv
module tb_plane_result_packetizer;

  localparam int TO = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        plane_en = 1'b0;
  logic [31:0] plane_data = '0;
  logic        surf_en = 1'b0;
  logic [31:0] surf_data = '0;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_last;
  logic        busy;
  logic [7:0]  ovf_cnt;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [7:0] exp_seq = 8'd0;
  logic [7:0] exp_ovf = 8'd0;

  logic [31:0] rx_data[$];
  logic        rx_last[$];
  int          rx_cyc[$];

  plane_result_packetizer #(
    .SYNC_BYTE  (8'hA5),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .plane_en  (plane_en),
    .plane_data(plane_data),
    .surf_en   (surf_en),
    .surf_data (surf_data),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .busy      (busy),
    .ovf_cnt   (ovf_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Collect every accepted stream word with the cycle it was accepted in.
  always @(negedge clk) begin
    if (rst === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
      rx_data.push_back(m_data);
      rx_last.push_back(m_last);
      rx_cyc.push_back(cyc);
    end
  end

  // Reference frame: header, plane, surface, XOR checksum.
  function automatic logic [31:0] exp_word(input int idx, input logic [7:0] seq,
                                           input logic [7:0] ovf, input logic has_p,
                                           input logic has_s, input logic [31:0] p,
                                           input logic [31:0] s);
    logic [31:0] h, pw, sw;
    h  = {8'hA5, seq, ovf, 6'b0, !has_s, !has_p};
    pw = has_p ? p : 32'h0;
    sw = has_s ? s : 32'h0;
    if (idx == 0) return h;
    else if (idx == 1) return pw;
    else if (idx == 2) return sw;
    else return h ^ pw ^ sw;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rx();
    rx_data.delete();
    rx_last.delete();
    rx_cyc.delete();
  endtask

  // Waiters return at the drive point of the cycle after the condition was seen.
  task automatic wait_words(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rx_data.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
  endtask

  task automatic wait_busy(input logic level, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy === level) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset m_valid: got %b expected 0", m_valid); end
    n_checks++;
    if (m_last !== 1'b0) begin n_fail++; $display("FAIL reset m_last: got %b expected 0", m_last); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", busy); end
    n_checks++;
    if (ovf_cnt !== 8'h00) begin n_fail++; $display("FAIL reset ovf_cnt: got %h expected 00", ovf_cnt); end
    n_checks++;
    if (m_data !== 32'h0) begin n_fail++; $display("FAIL reset m_data: got %h expected 0", m_data); end
    tick();
    rst = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_basic();
    int t;
    bit ok;
    clear_rx();
    m_ready = 1'b1;
    t = cyc;
    plane_en = 1'b1; plane_data = 32'h11223344;
    tick();
    plane_en = 1'b0;
    tick();
    tick();
    surf_en = 1'b1; surf_data = 32'h55667788;
    tick();
    surf_en = 1'b0;
    wait_words(4, 50, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL basic frame: got %0d words expected 4", rx_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (rx_data[i] !== exp_word(i, exp_seq, exp_ovf, 1, 1, 32'h11223344, 32'h55667788) ||
            rx_last[i] !== (i == 3)) begin
          n_fail++;
          $display("FAIL basic word%0d: got %h last=%b expected %h last=%b", i, rx_data[i],
                   rx_last[i], exp_word(i, exp_seq, exp_ovf, 1, 1, 32'h11223344, 32'h55667788),
                   (i == 3));
        end
        n_checks++;
        if (rx_cyc[i] !== t + 5 + i) begin
          n_fail++;
          $display("FAIL basic latency word%0d: got cycle %0d expected %0d", i, rx_cyc[i] - t,
                   5 + i);
        end
      end
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic idle after frame: got busy=%b valid=%b expected 0 0", busy,
                         m_valid);
    end
    tick();
    exp_seq++;
  endtask

  task automatic test_stall();
    logic pv, pr, pl;
    logic [31:0] pd;
    bit done;
    clear_rx();
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; done = 1'b0;
    for (int k = 0; k < 100; k++) begin
      plane_en = (k == 0); plane_data = 32'h11223344;
      surf_en = (k == 3); surf_data = 32'h55667788;
      m_ready = (k % 2 == 0);
      @(negedge clk);
      if (pv && !pr) begin
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== pd || m_last !== pl) begin
          n_fail++;
          $display("FAIL stall hold: got valid=%b data=%h last=%b expected 1 %h %b", m_valid,
                   m_data, m_last, pd, pl);
        end
      end
      pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
      if (rx_data.size() >= 4) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    plane_en = 1'b0; surf_en = 1'b0;
    tick();
    n_checks++;
    if (!done) begin
      n_fail++; $display("FAIL stall frame: got %0d words expected 4", rx_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (rx_data[i] !== exp_word(i, exp_seq, exp_ovf, 1, 1, 32'h11223344, 32'h55667788) ||
            rx_last[i] !== (i == 3)) begin
          n_fail++;
          $display("FAIL stall word%0d: got %h last=%b expected %h last=%b", i, rx_data[i],
                   rx_last[i], exp_word(i, exp_seq, exp_ovf, 1, 1, 32'h11223344, 32'h55667788),
                   (i == 3));
        end
      end
    end
    exp_seq++;
  endtask

  task automatic test_timeout();
    int t;
    bit ok;
    logic [31:0] d;
    for (int v = 0; v < 2; v++) begin
      clear_rx();
      m_ready = 1'b1;
      d = $urandom;
      t = cyc;
      if (v == 0) begin plane_en = 1'b1; plane_data = d; end
      else begin surf_en = 1'b1; surf_data = d; end
      tick();
      plane_en = 1'b0; surf_en = 1'b0;
      wait_words(4, TO + 50, ok);
      n_checks++;
      if (!ok) begin
        n_fail++; $display("FAIL timeout%0d frame: got %0d words expected 4", v, rx_data.size());
      end else begin
        n_checks++;
        if (rx_cyc[0] < t + TO || rx_cyc[0] > t + TO + 2) begin
          n_fail++;
          $display("FAIL timeout%0d delay: got %0d cycles expected %0d..%0d", v, rx_cyc[0] - t,
                   TO, TO + 2);
        end
        for (int i = 0; i < 4; i++) begin
          n_checks++;
          if (rx_data[i] !== exp_word(i, exp_seq, exp_ovf, v == 0, v == 1, d, d) ||
              rx_last[i] !== (i == 3)) begin
            n_fail++;
            $display("FAIL timeout%0d word%0d: got %h expected %h", v, i, rx_data[i],
                     exp_word(i, exp_seq, exp_ovf, v == 0, v == 1, d, d));
          end
        end
      end
      exp_seq++;
    end
  endtask

  task automatic test_overwrite();
    logic [31:0] pa, sa, pb, pc, sb;
    bit ok;
    clear_rx();
    pa = $urandom; sa = $urandom; pb = $urandom; pc = $urandom; sb = $urandom;
    m_ready = 1'b0;
    plane_en = 1'b1; plane_data = pa; surf_en = 1'b1; surf_data = sa;
    tick();
    plane_en = 1'b0; surf_en = 1'b0;
    wait_busy(1'b1, 10, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL overwrite start: got busy=%b expected 1", busy); end
    plane_en = 1'b1; plane_data = pb;
    tick();
    plane_data = pc;
    tick();
    plane_en = 1'b0; surf_en = 1'b1; surf_data = sb;
    tick();
    surf_en = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ovf_cnt !== 8'd1) begin n_fail++; $display("FAIL overwrite ovf_cnt: got %0d expected 1", ovf_cnt); end
    tick();
    m_ready = 1'b1;
    wait_words(8, 40, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL overwrite frames: got %0d words expected 8", rx_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (rx_data[i] !== exp_word(i, exp_seq, exp_ovf, 1, 1, pa, sa)) begin
          n_fail++; $display("FAIL overwrite f1 word%0d: got %h expected %h", i, rx_data[i],
                             exp_word(i, exp_seq, exp_ovf, 1, 1, pa, sa));
        end
        n_checks++;
        if (rx_data[4+i] !== exp_word(i, exp_seq + 8'd1, exp_ovf + 8'd1, 1, 1, pc, sb) ||
            rx_last[4+i] !== (i == 3)) begin
          n_fail++; $display("FAIL overwrite f2 word%0d: got %h expected %h", i, rx_data[4+i],
                             exp_word(i, exp_seq + 8'd1, exp_ovf + 8'd1, 1, 1, pc, sb));
        end
      end
    end
    exp_seq = exp_seq + 8'd2;
    exp_ovf = exp_ovf + 8'd1;
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] p, s;
    bit ok;
    int n0;
    clear_rx();
    p = $urandom; s = $urandom;
    m_ready = 1'b1;
    plane_en = 1'b1; plane_data = p; surf_en = 1'b1; surf_data = s;
    tick();
    plane_en = 1'b0; surf_en = 1'b0;
    wait_busy(1'b1, 10, ok);
    // Now in the cycle the PLANE word is presented.
    n_checks++;
    if (!ok || m_valid !== 1'b1 || m_data !== p) begin
      n_fail++; $display("FAIL rstmid plane word: got valid=%b data=%h expected 1 %h", m_valid,
                         m_data, p);
    end
    n_checks++;
    if (ovf_cnt !== exp_ovf) begin n_fail++; $display("FAIL rstmid ovf before: got %0d expected %0d", ovf_cnt, exp_ovf); end
    rst = 1'b0;
    #1;
    n_checks++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || busy !== 1'b0 || ovf_cnt !== 8'd0) begin
      n_fail++; $display("FAIL rstmid async: got valid=%b last=%b busy=%b ovf=%0d expected 0 0 0 0",
                         m_valid, m_last, busy, ovf_cnt);
    end
    repeat (2) tick();
    rst = 1'b1;
    exp_seq = 8'd0;
    exp_ovf = 8'd0;
    n0 = rx_data.size();
    repeat (10) tick();
    n_checks++;
    if (rx_data.size() !== n0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid resume: got %0d words busy=%b expected %0d 0",
                         rx_data.size(), busy, n0);
    end
    clear_rx();
    p = $urandom; s = $urandom;
    plane_en = 1'b1; plane_data = p; surf_en = 1'b1; surf_data = s;
    tick();
    plane_en = 1'b0; surf_en = 1'b0;
    wait_words(4, 30, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL rstmid frame: got %0d words expected 4", rx_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (rx_data[i] !== exp_word(i, exp_seq, exp_ovf, 1, 1, p, s)) begin
          n_fail++; $display("FAIL rstmid word%0d: got %h expected %h", i, rx_data[i],
                             exp_word(i, exp_seq, exp_ovf, 1, 1, p, s));
        end
      end
    end
    exp_seq++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ps[256];
    logic [31:0] ss[256];
    logic [7:0] seq0;
    bit ok;
    clear_rx();
    m_ready = 1'b1;
    seq0 = exp_seq;
    for (int f = 0; f < 256; f++) begin
      ps[f] = $urandom; ss[f] = $urandom;
      plane_en = 1'b1; plane_data = ps[f]; surf_en = 1'b1; surf_data = ss[f];
      tick();
      plane_en = 1'b0; surf_en = 1'b0;
      wait_busy(1'b0, 20, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL b2b busy low before frame %0d: got 1 expected 0", f); end
      wait_busy(1'b1, 20, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL b2b frame %0d start: got busy 0 expected 1", f); end
    end
    wait_words(1024, 50, ok);
    n_checks++;
    if (!ok || rx_data.size() !== 1024) begin
      n_fail++; $display("FAIL b2b word count: got %0d expected 1024", rx_data.size());
    end else begin
      for (int f = 0; f < 256; f++) begin
        for (int i = 0; i < 4; i++) begin
          n_checks++;
          if (rx_data[4*f+i] !== exp_word(i, seq0 + 8'(f), exp_ovf, 1, 1, ps[f], ss[f]) ||
              rx_last[4*f+i] !== (i == 3)) begin
            n_fail++;
            $display("FAIL b2b frame%0d word%0d: got %h expected %h", f, i, rx_data[4*f+i],
                     exp_word(i, seq0 + 8'(f), exp_ovf, 1, 1, ps[f], ss[f]));
          end
        end
        // Next pair is already pending, so exactly one idle cycle separates frames.
        if (f < 255) begin
          n_checks++;
          if (rx_cyc[4*f+4] - rx_cyc[4*f+3] !== 2) begin
            n_fail++; $display("FAIL b2b gap after frame %0d: got %0d expected 2", f,
                               rx_cyc[4*f+4] - rx_cyc[4*f+3]);
          end
        end
      end
    end
    // 256 frames bring the sequence number back to where it started.
  endtask

  task automatic test_random();
    int kp, ks, lim;
    bit has_p, has_s, done;
    logic [31:0] p, s;
    for (int it = 0; it < 40; it++) begin
      clear_rx();
      p = $urandom; s = $urandom;
      if ($urandom_range(0, 19) == 0) begin
        has_p = ($urandom_range(0, 1) == 0);
        has_s = !has_p;
        kp = has_p ? 0 : -1;
        ks = has_s ? 0 : -1;
      end else begin
        has_p = 1'b1; has_s = 1'b1;
        kp = $urandom_range(0, 4);
        ks = $urandom_range(0, 4);
      end
      lim = TO + 300;
      done = 1'b0;
      for (int k = 0; k < lim; k++) begin
        plane_en = (k == kp); plane_data = p;
        surf_en = (k == ks); surf_data = s;
        m_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (rx_data.size() >= 4) begin
          done = 1'b1;
          break;
        end
        tick();
      end
      plane_en = 1'b0; surf_en = 1'b0;
      tick();
      n_checks++;
      if (!done) begin
        n_fail++; $display("FAIL random it%0d frame: got %0d words expected 4", it, rx_data.size());
      end else begin
        for (int i = 0; i < 4; i++) begin
          n_checks++;
          if (rx_data[i] !== exp_word(i, exp_seq, exp_ovf, has_p, has_s, p, s) ||
              rx_last[i] !== (i == 3)) begin
            n_fail++;
            $display("FAIL random it%0d word%0d: got %h last=%b expected %h last=%b", it, i,
                     rx_data[i], rx_last[i], exp_word(i, exp_seq, exp_ovf, has_p, has_s, p, s),
                     (i == 3));
          end
        end
      end
      exp_seq++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_timeout();
    test_overwrite();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
